// File: rtl/noc_output_link_scheduler.sv
// Wormhole output-link scheduler: round-robin packet arbitration among the input ports,
// link held from head to tail flit, with downstream credit tracking.
module noc_output_link_scheduler #(
  parameter int N_PORTS = 5,
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               credit_in,
  output logic [N_PORTS-1:0] grant,
  output logic [N_PORTS-1:0] xbar_sel,
  output logic               flit_valid,
  output logic [CRED_W-1:0]  credit_cnt,
  output logic               locked,
  output logic               err_ovf,
  output logic               dbg_state
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_PORTS - 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   winner;
  logic               win_found;
  logic [N_PORTS-1:0] xbar_q, xbar_d;
  logic [CRED_W-1:0]  credit_q;
  logic               err_q;
  logic               xfer;
  logic               xfer_tail;

  function automatic logic [N_PORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just after the port that last completed a packet.
  always_comb begin
    winner    = last_q;
    win_found = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      if (!win_found && req[(int'(last_q) + k) % N_PORTS]) begin
        winner    = IDX_W'((int'(last_q) + k) % N_PORTS);
        win_found = 1'b1;
      end
    end
  end

  // Flow control: req[i] is the valid of input i's head flit, grant[i] is its ready;
  // a flit moves only in a cycle where both are high, and only the owner is ever granted.
  always_comb begin
    grant = '0;
    if (state_q == ST_LOCKED && req[owner_q] && credit_q != '0) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign xfer      = |grant;
  assign xfer_tail = xfer && tail[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    xbar_d  = xbar_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_LOCKED;
          owner_d = winner;
          xbar_d  = onehot(winner);
        end
      end
      ST_LOCKED: begin
        if (xfer_tail) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          xbar_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        xbar_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      xbar_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      xbar_q  <= xbar_d;
    end
  end

  // A transfer and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CRED_MAX;
      err_q    <= 1'b0;
    end else if (xfer && !credit_in) begin
      credit_q <= credit_q - CRED_ONE;
    end else if (credit_in && !xfer) begin
      if (credit_q == CRED_MAX) begin
        err_q <= 1'b1;
      end else begin
        credit_q <= credit_q + CRED_ONE;
      end
    end
  end

  assign xbar_sel   = xbar_q;
  assign flit_valid = xfer;
  assign credit_cnt = credit_q;
  assign locked     = (state_q == ST_LOCKED);
  assign err_ovf    = err_q;
  assign dbg_state  = state_q;

endmodule
